// File: rtl/wfg_stim_mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// wfg_stim_mem_arb_pkg
//
// Shared definitions for the stimulus-SRAM read-port arbiter.
//   MEM_AW / MEM_DW : default SRAM address and data widths
//   mem_addr_t      : SRAM address type
//   mem_data_t      : SRAM data word type
//   rr_next()       : round-robin pointer increment with wrap at n
// -----------------------------------------------------------------------------
package wfg_stim_mem_arb_pkg;

    localparam int MEM_AW = 10;
    localparam int MEM_DW = 32;

    typedef logic [MEM_AW-1:0] mem_addr_t;
    typedef logic [MEM_DW-1:0] mem_data_t;

    // Next round-robin start position after requester 'ptr' has been served.
    function automatic int rr_next(input int ptr, input int n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage : wfg_stim_mem_arb_pkg

// File: rtl/wfg_rr_pick.sv
// -----------------------------------------------------------------------------
// wfg_rr_pick
//
// Purely combinational round-robin picker. Scans the request vector starting
// at i_ptr and wrapping modulo N; the first asserted request wins.
//
// Ports:
//   i_req  [N-1:0]  request vector
//   i_ptr  [IW-1:0] position with highest priority this cycle (0..N-1)
//   o_gnt  [N-1:0]  one-hot winner, all zero when no request
//   o_idx  [IW-1:0] binary index of the winner, 0 when no request
//   o_any           at least one request is asserted
// -----------------------------------------------------------------------------
module wfg_rr_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    // One extra bit so ptr + offset cannot overflow before the modulo fold.
    logic [IW:0]   w_sum;
    logic [IW-1:0] w_cand;

    always_comb begin
        // NOTE: every output and temporary gets a default before the loop so
        // no path leaves a value unassigned, which would infer a latch.
        o_gnt  = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        w_sum  = '0;
        w_cand = '0;
        for (int off = 0; off < N; off++) begin
            w_sum = {1'b0, i_ptr} + (IW+1)'(off);
            if (w_sum >= (IW+1)'(N)) begin
                w_sum = w_sum - (IW+1)'(N);
            end
            w_cand = w_sum[IW-1:0];
            if (!o_any && i_req[w_cand]) begin
                o_any         = 1'b1;
                o_idx         = w_cand;
                o_gnt[w_cand] = 1'b1;
            end
        end
    end

endmodule : wfg_rr_pick

// File: rtl/wfg_stim_mem_arbiter.sv
// -----------------------------------------------------------------------------
// wfg_stim_mem_arbiter
//
// Shares the single read port of the stimulus SRAM among NREQ readers with
// round-robin arbitration and an optional per-requester lock for bursts.
// A grant is combinational and drives the SRAM in the same cycle; the read
// data comes back exactly one cycle later, tagged with a one-hot rvalid_o.
//
// Ports:
//   clk       clock
//   rst_n     asynchronous active-low reset
//   req_i     [NREQ-1:0]     read request per requester, held until granted
//   lock_i    [NREQ-1:0]     keep ownership after this grant while req stays
//   addr_i    [NREQ*AW-1:0]  request addresses, requester k at [k*AW +: AW]
//   gnt_o     [NREQ-1:0]     one-hot grant (combinational)
//   rvalid_o  [NREQ-1:0]     one-hot read-data valid, one cycle after grant
//   rdata_o   [DW-1:0]       read data, zero when no rvalid_o bit is set
//   csb1                     SRAM chip select, active low
//   addr1     [AW-1:0]       SRAM address
//   dout1     [DW-1:0]       SRAM read data, valid the cycle after csb1=0
// -----------------------------------------------------------------------------
module wfg_stim_mem_arbiter
    import wfg_stim_mem_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = MEM_AW,
    parameter int DW   = MEM_DW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_i,
    input  logic [NREQ-1:0]    lock_i,
    input  logic [NREQ*AW-1:0] addr_i,
    output logic [NREQ-1:0]    gnt_o,
    output logic [NREQ-1:0]    rvalid_o,
    output logic [DW-1:0]      rdata_o,
    output logic               csb1,
    output logic [AW-1:0]      addr1,
    input  logic [DW-1:0]      dout1
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Arbitration state
    logic          r_arb_en;    // low during reset and the first cycle after
    logic [IW-1:0] r_rr_ptr;    // round-robin start position
    logic          r_lock_vld;  // an owner holds the port
    logic [IW-1:0] r_lock_id;   // current lock owner

    // Response tag pipeline
    logic          r_rvld;
    logic [IW-1:0] r_rsel;

    // Picker results and final winner
    logic [NREQ-1:0] w_pick_gnt;
    logic [IW-1:0]   w_pick_idx;
    logic            w_pick_any;
    logic            w_lock_hit;
    logic            w_grant;
    logic [IW-1:0]   w_win;

    wfg_rr_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_pick (
        .i_req (req_i),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_pick_gnt),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    // The lock only holds while its owner keeps requesting; once the owner
    // drops req_i the round-robin picker takes over in the same cycle.
    assign w_lock_hit = r_arb_en && r_lock_vld && req_i[r_lock_id];
    assign w_grant    = w_lock_hit || (r_arb_en && w_pick_any);
    assign w_win      = w_lock_hit ? r_lock_id : w_pick_idx;

    // Grant and SRAM request, combinational so the read issues this cycle.
    always_comb begin
        gnt_o = '0;
        addr1 = '0;
        if (w_lock_hit) begin
            gnt_o[r_lock_id] = 1'b1;
        end else if (r_arb_en) begin
            gnt_o = w_pick_gnt;
        end
        if (w_grant) begin
            addr1 = addr_i[int'(w_win)*AW +: AW];
        end
    end

    assign csb1 = ~w_grant;

    // Response routing: the SRAM output is only forwarded while a response
    // is due, so idle cycles read back as zero.
    always_comb begin
        rvalid_o = '0;
        for (int k = 0; k < NREQ; k++) begin
            rvalid_o[k] = r_rvld && (r_rsel == IW'(k));
        end
    end

    assign rdata_o = r_rvld ? dout1 : '0;

    // NOTE: state updates use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_arb_en   <= 1'b0;
            r_rr_ptr   <= '0;
            r_lock_vld <= 1'b0;
            r_lock_id  <= '0;
            r_rvld     <= 1'b0;
            r_rsel     <= '0;
        end else begin
            r_arb_en <= 1'b1;
            r_rvld   <= w_grant;
            if (w_grant) begin
                r_rsel     <= w_win;
                r_lock_vld <= lock_i[w_win];
                r_lock_id  <= w_win;
                // A lock continuation leaves the fairness pointer alone so the
                // others resume exactly where they were when the burst began.
                if (!w_lock_hit) begin
                    r_rr_ptr <= IW'(rr_next(int'(w_pick_idx), NREQ));
                end
            end else begin
                // No grant means the owner (if any) has dropped its request.
                r_lock_vld <= 1'b0;
            end
        end
    end

endmodule : wfg_stim_mem_arbiter

// File: doc/wfg_stim_mem_arbiter.md
Name: wfg_stim_mem_arbiter

Overview:
Shares the single read port of the stimulus SRAM (csb1/addr1/dout1) among NREQ readers, for example several wfg_stim_mem channels plus a debug readback path. It uses round-robin arbitration with an optional per-requester lock for back-to-back bursts. It sits between the requesters and the SRAM macro, and tags each read response back to the requester that issued it.

Parameters:
NREQ, 2, number of requesters (2..8)
AW, 10, SRAM address width
DW, 32, SRAM data width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_i  in  NREQ  read request per requester, held until granted
lock_i  in  NREQ  keep ownership after this grant while req stays high
addr_i  in  NREQ*AW  flattened request addresses; requester k uses bits [k*AW +: AW]
gnt_o  out  NREQ  one-hot grant, combinational; request is accepted in the cycle gnt_o[k]=1
rvalid_o  out  NREQ  one-hot read-data valid, one cycle after the grant
rdata_o  out  DW  read data, shared by all requesters, qualified by rvalid_o
csb1  out  1  SRAM chip select, active low
addr1  out  AW  SRAM address
dout1  in  DW  SRAM read data, valid in the cycle after csb1=0

Behaviour:
- Interface (already decided): one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: gnt_o=0, rvalid_o=0, rdata_o=0, csb1=1, addr1=0, rr_ptr=0, owner lock cleared, rsel_q=0.
- Arbitration start-up:
  - Arbitration is gated by flop arb_en_q, which resets to 0 and sets to 1 on the first clock edge after rst_n deasserts.
  - Consequently gnt_o=0 and csb1=1 during reset and for the first cycle after it.
- Winner selection in cycle T:
  - If lock_q is valid and req_i[lock_id_q]=1, lock_id_q wins.
  - Otherwise the winner is the first asserted req_i scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
  - No request: gnt_o=0, csb1=1, addr1=0.
- Grant cycle T (combinational): gnt_o[w]=1, csb1=0, addr1=addr_i[w].
- Edge at end of T:
  - rsel_q<=w, rvld_q<=1.
  - rr_ptr<=(w+1) mod NREQ, unless the grant was a lock continuation; then rr_ptr is unchanged.
  - lock_q<=lock_i[w], lock_id_q<=w.
- Response cycle T+1: rvalid_o[rsel_q]=rvld_q, rdata_o=dout1 while rvld_q=1, else 0. Latency from grant to data is exactly 1 cycle.
- Throughput: one read per cycle. A requester holding req_i high gets a grant every NREQ cycles under full load, or every cycle if alone or locked.
- Lock release: lock_q clears when the owner drops req_i, or when it is granted with lock_i=0. Clearing takes effect in the same cycle's arbitration, with no idle cycle.
- Requester rules:
  - req_i and addr_i must be stable until gnt_o.
  - A requester may issue its next request in the same cycle its rvalid_o is high.
- Simultaneous events: a grant in T and the response for T-1 in the same cycle is the normal pipelined case.
- Reset mid-operation:
  - Outstanding responses are dropped; rvalid_o goes 0 immediately on asynchronous assert.
  - csb1 goes 1 immediately.
  - No response is produced for a read granted before reset.
- NREQ=1 degenerates to a pass-through with the 1-cycle rvalid.

Decomposition:
- Package wfg_stim_mem_arb_pkg holds:
  - MEM_AW=10, MEM_DW=32
  - typedef mem_addr_t, mem_data_t
  - function rr_next(ptr, n)
- Sub-module wfg_rr_pick: purely combinational round-robin picker.
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, binary index, any.
- The top holds the lock, pointer and response-tag pipeline.

Test Plan:
1. Reset release, NREQ=2, req_i=2'b11 held from reset → no grant in the first cycle after rst_n rises; then gnt_o alternates 01,10,01,10. rvalid_o follows one cycle later with dout1 mirrored on rdata_o.
2. Requester 0 only, addr 0x3FF then 0x000 on consecutive grants → addr1=0x3FF then 0x000 with csb1=0 both cycles. rvalid_o[0]=1 in both following cycles; rdata_o equals the model SRAM contents.
3. NREQ=3, req=3'b111, lock_i[1]=1 for 4 grants → grants 0,1,1,1,1. After lock_i[1] drops, the next grant goes to 2, then 0; rr_ptr was not advanced during the locked grants.
4. Requester 2 drops req while locked (NREQ=3, req 2→0) → the lock clears the same cycle and requester 0 is granted immediately, with no bubble.
5. Assert rst_n low in the cycle after a grant to requester 1 → rvalid_o=0 and csb1=1 immediately. After release, no stale rvalid_o[1] appears and rr_ptr=0.
6. Random req/lock/addr traffic for 10k cycles against a scoreboard → every grant gets exactly one rvalid to the same requester with the correct data. No starvation: any waiting requester without an active foreign lock is granted within NREQ cycles.
